// File: rtl/lcd_nibble_receiver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_nibble_receiver
// Purpose  : Responder for a 4-bit character-LCD write bus. Registers the
//            bus, counts init nibbles, pairs nibbles into bytes, tracks the
//            DDRAM address and raises sticky timing/protocol error flags.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_nibble_receiver #(
    parameter int unsigned INIT_NIBBLES = 4,
    parameter int unsigned MIN_E_HIGH   = 12,
    parameter int unsigned MIN_NIB_GAP  = 50,
    parameter int unsigned PAIR_TIMEOUT = 4000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_rs,
    input  logic       lcd_w,
    input  logic       lcd_e,
    input  logic [3:0] data,
    input  logic       err_clr,
    output logic       init_done,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic [6:0] ddram_addr,
    output logic       read_seen,
    output logic       pulse_err,
    output logic       gap_err,
    output logic       sync_err
);

    localparam int unsigned c_ic_w = (INIT_NIBBLES > 1) ? $clog2(INIT_NIBBLES) : 1;
    localparam int unsigned c_pt_w = $clog2(PAIR_TIMEOUT + 1);

    localparam logic [c_ic_w-1:0] c_init_last    = c_ic_w'(INIT_NIBBLES - 1);
    localparam logic [c_pt_w-1:0] c_pair_timeout = c_pt_w'(PAIR_TIMEOUT);
    localparam logic [15:0]       c_min_e_high   = 16'(MIN_E_HIGH);
    localparam logic [15:0]       c_min_nib_gap  = 16'(MIN_NIB_GAP);
    localparam logic [15:0]       c_cnt_max      = 16'hFFFF;

    localparam logic [1:0] c_st_init = 2'd0;
    localparam logic [1:0] c_st_hi   = 2'd1;
    localparam logic [1:0] c_st_lo   = 2'd2;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic       r_rs;
    logic       r_w;
    logic       r_e;
    logic [3:0] r_data;
    logic       r_e_prev;
    logic       r_hold_rs;
    logic       r_hold_w;
    logic [3:0] r_hold_data;
    logic       r_fall_q;

    logic w_fall;
    logic w_rise;
    logic w_wr_fall;
    logic w_rd_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs        <= 1'b0;
            r_w         <= 1'b0;
            r_e         <= 1'b0;
            r_data      <= 4'h0;
            r_e_prev    <= 1'b0;
            r_hold_rs   <= 1'b0;
            r_hold_w    <= 1'b0;
            r_hold_data <= 4'h0;
            r_fall_q    <= 1'b0;
        end else begin
            r_rs     <= lcd_rs;
            r_w      <= lcd_w;
            r_e      <= lcd_e;
            r_data   <= data;
            r_e_prev <= r_e;
            r_fall_q <= w_fall;
            if (r_e) begin
                r_hold_rs   <= r_rs;
                r_hold_w    <= r_w;
                r_hold_data <= r_data;
            end
        end
    end

    assign w_fall    = r_e_prev & ~r_e;
    assign w_rise    = ~r_e_prev & r_e;
    // Nibble consumption happens one cycle after the detected fall.
    assign w_wr_fall = r_fall_q & ~r_hold_w;
    assign w_rd_fall = r_fall_q & r_hold_w;

    // ------------------------------------------------------------------
    // Strobe timing counters. Both count the cycle of the edge itself, so
    // the value seen at the opposite edge equals the number of samples.
    // ------------------------------------------------------------------
    logic [15:0] r_e_cnt;
    logic [15:0] r_gap_cnt;
    logic        r_rise_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e_cnt     <= 16'h0;
            r_gap_cnt   <= 16'h0;
            r_rise_seen <= 1'b0;
        end else begin
            if (w_rise) begin
                r_e_cnt     <= 16'h1;
                r_rise_seen <= 1'b1;
            end else if (r_e && (r_e_cnt != c_cnt_max)) begin
                r_e_cnt <= r_e_cnt + 16'h1;
            end

            if (w_fall) begin
                r_gap_cnt <= 16'h1;
            end else if (!r_e && (r_gap_cnt != c_cnt_max)) begin
                r_gap_cnt <= r_gap_cnt + 16'h1;
            end
        end
    end

    logic w_pulse_evt;
    logic w_gap_evt;

    assign w_pulse_evt = w_fall & (r_e_cnt < c_min_e_high);
    assign w_gap_evt   = w_rise & r_rise_seen & (r_gap_cnt < c_min_nib_gap);

    // ------------------------------------------------------------------
    // Nibble pairing state machine
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_ic_w-1:0] r_init_cnt;
    logic [3:0]        r_hi_nib;
    logic              r_hi_rs;
    logic [c_pt_w-1:0] r_pair_cnt;
    logic              r_init_done;
    logic              r_byte_valid;
    logic [7:0]        r_byte_data;
    logic              r_byte_rs;
    logic [6:0]        r_ddram_addr;
    logic              r_read_seen;

    logic [7:0] w_new_byte;
    logic       w_rs_match;
    logic       w_timeout;
    logic       w_sync_evt;
    logic [6:0] w_addr_next;

    assign w_new_byte = {r_hi_nib, r_hold_data};
    assign w_rs_match = (r_hold_rs == r_hi_rs);
    assign w_timeout  = (r_state == c_st_lo) && !w_wr_fall && (r_pair_cnt == c_pair_timeout);
    assign w_sync_evt = ((r_state == c_st_lo) && w_wr_fall && !w_rs_match) || w_timeout;

    // Data writes auto-increment across the two 40-character display lines.
    always_comb begin
        w_addr_next = r_ddram_addr;
        if (r_hold_rs) begin
            if (r_ddram_addr == 7'h27) begin
                w_addr_next = 7'h40;
            end else if (r_ddram_addr == 7'h67) begin
                w_addr_next = 7'h00;
            end else begin
                w_addr_next = r_ddram_addr + 7'h1;
            end
        end else if ((w_new_byte == 8'h01) || (w_new_byte == 8'h02)) begin
            w_addr_next = 7'h00;
        end else if (w_new_byte[7]) begin
            w_addr_next = w_new_byte[6:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_init;
            r_init_cnt   <= '0;
            r_hi_nib     <= 4'h0;
            r_hi_rs      <= 1'b0;
            r_pair_cnt   <= '0;
            r_init_done  <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'h00;
            r_byte_rs    <= 1'b0;
            r_ddram_addr <= 7'h00;
            r_read_seen  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_read_seen  <= w_rd_fall;
            case (r_state)
                c_st_init: begin
                    if (w_wr_fall) begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                        if (r_init_cnt == c_init_last) begin
                            r_init_done <= 1'b1;
                            r_state     <= c_st_hi;
                        end
                    end
                end
                c_st_hi: begin
                    if (w_wr_fall) begin
                        r_hi_nib   <= r_hold_data;
                        r_hi_rs    <= r_hold_rs;
                        r_pair_cnt <= '0;
                        r_state    <= c_st_lo;
                    end
                end
                c_st_lo: begin
                    if (w_wr_fall) begin
                        if (w_rs_match) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= w_new_byte;
                            r_byte_rs    <= r_hold_rs;
                            r_ddram_addr <= w_addr_next;
                            r_state      <= c_st_hi;
                        end else begin
                            // RS changed mid-byte: restart the pair from this nibble.
                            r_hi_nib   <= r_hold_data;
                            r_hi_rs    <= r_hold_rs;
                            r_pair_cnt <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_st_hi;
                    end else begin
                        r_pair_cnt <= r_pair_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_init;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a new event wins over a simultaneous clear.
    // ------------------------------------------------------------------
    logic r_pulse_err;
    logic r_gap_err;
    logic r_sync_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_err <= 1'b0;
            r_gap_err   <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (w_pulse_evt) begin
                r_pulse_err <= 1'b1;
            end else if (err_clr) begin
                r_pulse_err <= 1'b0;
            end

            if (w_gap_evt) begin
                r_gap_err <= 1'b1;
            end else if (err_clr) begin
                r_gap_err <= 1'b0;
            end

            if (w_sync_evt) begin
                r_sync_err <= 1'b1;
            end else if (err_clr) begin
                r_sync_err <= 1'b0;
            end
        end
    end

    assign init_done  = r_init_done;
    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign byte_rs    = r_byte_rs;
    assign ddram_addr = r_ddram_addr;
    assign read_seen  = r_read_seen;
    assign pulse_err  = r_pulse_err;
    assign gap_err    = r_gap_err;
    assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_nibble_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_nibble_receiver
// Purpose  : Scoreboard bench for lcd_nibble_receiver using directed strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_nibble_receiver;

    localparam int PAIR_TIMEOUT = 4000;

    logic       clk;
    logic       reset_n;
    logic       lcd_rs;
    logic       lcd_w;
    logic       lcd_e;
    logic [3:0] data;
    logic       err_clr;
    logic       init_done;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic [6:0] ddram_addr;
    logic       read_seen;
    logic       pulse_err;
    logic       gap_err;
    logic       sync_err;

    lcd_nibble_receiver #(
        .INIT_NIBBLES (4),
        .MIN_E_HIGH   (12),
        .MIN_NIB_GAP  (50),
        .PAIR_TIMEOUT (PAIR_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lcd_rs     (lcd_rs),
        .lcd_w      (lcd_w),
        .lcd_e      (lcd_e),
        .data       (data),
        .err_clr    (err_clr),
        .init_done  (init_done),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_rs    (byte_rs),
        .ddram_addr (ddram_addr),
        .read_seen  (read_seen),
        .pulse_err  (pulse_err),
        .gap_err    (gap_err),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rs;
        logic [7:0] b;
        logic [6:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   last_fall  = 0;
    int   rd_cnt     = 0;
    logic prev_init  = 1'b0;
    exp_t cur;

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented byte against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && byte_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", int'(byte_data), -1);
            end else begin
                cur = exp_q.pop_front();
                check("byte_data", int'(byte_data), int'(cur.b));
                check("byte_rs", int'(byte_rs), int'(cur.rs));
                check("ddram_addr", int'(ddram_addr), int'(cur.a));
                check("byte_latency", cyc - last_fall, 3);
            end
        end
        if (reset_n && read_seen) rd_cnt = rd_cnt + 1;
        if (reset_n && init_done && !prev_init) check("init_latency", cyc - last_fall, 3);
        prev_init = init_done;
    end

    // Caller must be at a negedge; E is sampled high ehigh times then low gap times.
    task automatic strobe(input logic rs, input logic w, input logic [3:0] nib,
                          input int ehigh, input int gap);
        lcd_rs = rs;
        lcd_w  = w;
        data   = nib;
        lcd_e  = 1'b1;
        repeat (ehigh) @(negedge clk);
        lcd_e     = 1'b0;
        last_fall = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input logic [6:0] a);
        exp_q.push_back('{rs: rs, b: b, a: a});
        strobe(rs, 1'b0, b[7:4], 12, 50);
        strobe(rs, 1'b0, b[3:0], 12, 50);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_init_done"}, int'(init_done), 0);
        check({tag, "_byte_valid"}, int'(byte_valid), 0);
        check({tag, "_byte_data"}, int'(byte_data), 0);
        check({tag, "_byte_rs"}, int'(byte_rs), 0);
        check({tag, "_ddram_addr"}, int'(ddram_addr), 0);
        check({tag, "_read_seen"}, int'(read_seen), 0);
        check({tag, "_errs"}, int'({pulse_err, gap_err, sync_err}), 0);
    endtask

    task automatic do_init();
        logic [3:0] nibs [4];
        nibs[0] = 4'h3; nibs[1] = 4'h3; nibs[2] = 4'h3; nibs[3] = 4'h2;
        for (int i = 0; i < 4; i++) begin
            check("init_done_before", int'(init_done), 0);
            strobe(1'b0, 1'b0, nibs[i], 12, 50);
        end
        check("init_done_after", int'(init_done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        lcd_rs  = 1'b0;
        lcd_w   = 1'b0;
        lcd_e   = 1'b0;
        data    = 4'h0;
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        do_init();
        check("pulse_err_after_init", int'(pulse_err), 0);
        check("gap_err_after_init", int'(gap_err), 0);

        send_byte(1'b0, 8'h85, 7'h05);
        send_byte(1'b1, 8'h41, 7'h06);
        send_byte(1'b1, 8'h42, 7'h07);
        send_byte(1'b0, 8'hA7, 7'h27);
        send_byte(1'b1, 8'h33, 7'h40);
        send_byte(1'b0, 8'hE7, 7'h67);
        send_byte(1'b1, 8'h34, 7'h00);
        send_byte(1'b1, 8'h35, 7'h01);
        send_byte(1'b0, 8'h01, 7'h00);
        send_byte(1'b1, 8'h36, 7'h01);
        send_byte(1'b0, 8'h02, 7'h00);
        send_byte(1'b0, 8'hFF, 7'h7F);
        send_byte(1'b1, 8'h37, 7'h00);
        send_byte(1'b0, 8'hAA, 7'h2A);
        send_byte(1'b0, 8'h38, 7'h2A);
        send_byte(1'b1, 8'h39, 7'h2B);
        check("errs_clean_traffic", int'({pulse_err, gap_err, sync_err}), 0);

        // Short E pulse: flagged but nibble still pairs.
        exp_q.push_back('{rs: 1'b1, b: 8'h48, a: 7'h2C});
        strobe(1'b1, 1'b0, 4'h4, 5, 50);
        strobe(1'b1, 1'b0, 4'h8, 12, 50);
        check("pulse_err_set", int'(pulse_err), 1);
        check("gap_err_clear", int'(gap_err), 0);

        // Short gap before the second nibble.
        exp_q.push_back('{rs: 1'b1, b: 8'h5A, a: 7'h2D});
        strobe(1'b1, 1'b0, 4'h5, 12, 20);
        strobe(1'b1, 1'b0, 4'hA, 12, 50);
        check("gap_err_set", int'(gap_err), 1);
        check("sync_err_clear", int'(sync_err), 0);
        clear_errors();
        check("err_clr", int'({pulse_err, gap_err, sync_err}), 0);

        // Pair timeout: high nibble abandoned, no byte.
        strobe(1'b0, 1'b0, 4'h9, 12, 50);
        repeat (PAIR_TIMEOUT + 20) @(negedge clk);
        check("sync_err_timeout", int'(sync_err), 1);
        check("queue_empty_timeout", exp_q.size(), 0);
        send_byte(1'b0, 8'hC0, 7'h40);
        clear_errors();
        check("sync_err_cleared", int'(sync_err), 0);

        // RS mismatch: restart from the second nibble.
        strobe(1'b0, 1'b0, 4'h3, 12, 50);
        check("sync_err_pre_mismatch", int'(sync_err), 0);
        strobe(1'b1, 1'b0, 4'h1, 12, 50);
        check("sync_err_mismatch", int'(sync_err), 1);
        exp_q.push_back('{rs: 1'b1, b: 8'h12, a: 7'h41});
        strobe(1'b1, 1'b0, 4'h2, 12, 50);
        clear_errors();

        // Read strobe between halves.
        exp_q.push_back('{rs: 1'b1, b: 8'h41, a: 7'h42});
        strobe(1'b1, 1'b0, 4'h4, 12, 50);
        strobe(1'b1, 1'b1, 4'hF, 12, 50);
        check("read_seen_count", rd_cnt, 1);
        strobe(1'b1, 1'b0, 4'h1, 12, 50);
        check("sync_err_after_read", int'(sync_err), 0);

        // Reset mid-byte.
        strobe(1'b0, 1'b0, 4'h7, 12, 50);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("midreset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        do_init();
        send_byte(1'b0, 8'h80, 7'h00);

        repeat (10) @(negedge clk);
        check("queue_empty_end", exp_q.size(), 0);
        check("read_seen_final", rd_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
